// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Default widths, the zero-register index and the writeback bundle.
package regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam logic [ADDR_W_DEF-1:0] XZR_REG = 5'd31;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] wa;
        logic [DATA_W_DEF-1:0] wd;
    } wb_req_t;

    typedef enum logic [1:0] {
        NONE,
        PIPE,
        FIFO,
        BYPASS
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between WB stage, multi-cycle unit, decode and the arbiter.
import regfile_pkg::*;

interface regfile_wb_arbiter_if #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_wa;
    logic [DATA_W-1:0] pipe_wd;
    logic              mc_valid;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_wa;
    logic [DATA_W-1:0] mc_wd;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_wa;
    logic [ADDR_W-1:0] chk_ra1;
    logic [ADDR_W-1:0] chk_ra2;
    logic [ADDR_W-1:0] chk_wa;
    logic              stall;
    logic [31:0]       pending;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd,
        input  mc_valid, mc_wa, mc_wd,
        input  issue_valid, issue_wa,
        input  chk_ra1, chk_ra2, chk_wa,
        output mc_ready, stall, pending,
        output rf_we, rf_wa, rf_wd
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd,
        output mc_valid, mc_wa, mc_wd,
        output issue_valid, issue_wa,
        output chk_ra1, chk_ra2, chk_wa,
        input  mc_ready, stall, pending,
        input  rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// In-order buffer for multi-cycle results awaiting the write port.
import regfile_pkg::*;

module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     head_o,
    output logic empty_o,
    output logic full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          wr;
    logic          rd;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full buffer refuses pushes even while it drains.
    assign wr      = push_i && !full_o;
    assign rd      = pop_i && !empty_o;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wr_q <= inc(wr_q);
            if (rd) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB and a multi-cycle unit,
// tracking outstanding multi-cycle destinations for decode.
import regfile_pkg::*;

module regfile_wb_arbiter #(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                FIFO_DEPTH = 2,
    parameter int                STARVE_MAX = 4,
    parameter logic [ADDR_W-1:0] XZR        = XZR_REG
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_src_e       src;
    wb_req_t       head;
    wb_req_t       mc_req;
    logic          empty;
    logic          full;
    logic          ready_q;
    logic          pipe_win;
    logic          mc_live;
    logic          push;
    logic          pop;
    logic          commit;
    logic [31:0]   pend_q;
    logic [31:0]   pend_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          hit;

    assign mc_req   = '{we: 1'b1, wa: bus.mc_wa, wd: bus.mc_wd};
    assign bus.mc_ready = ready_q && !full;

    assign pipe_win = reset && bus.pipe_we && (bus.pipe_wa != XZR);
    assign mc_live  = bus.mc_valid && bus.mc_ready && (bus.mc_wa != XZR);

    always_comb begin
        src = NONE;
        priority case (1'b1)
            pipe_win: src = PIPE;
            !empty:   src = FIFO;
            mc_live:  src = BYPASS;
            default:  src = NONE;
        endcase
    end

    assign pop    = (src == FIFO);
    assign push   = mc_live && (src != BYPASS);
    assign commit = (src == FIFO) || (src == BYPASS);

    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_wa = '0;
        bus.rf_wd = '0;
        unique case (src)
            PIPE: begin
                bus.rf_we = 1'b1;
                bus.rf_wa = bus.pipe_wa;
                bus.rf_wd = bus.pipe_wd;
            end
            FIFO: begin
                bus.rf_we = head.we;
                bus.rf_wa = head.wa;
                bus.rf_wd = head.wd;
            end
            BYPASS: begin
                bus.rf_we = mc_req.we;
                bus.rf_wa = mc_req.wa;
                bus.rf_wd = mc_req.wd;
            end
            default: ;
        endcase
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wb_req_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .data_i  (mc_req),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

    // A new issue outranks a commit to the same register.
    always_comb begin
        pend_d = pend_q;
        if (commit) pend_d[bus.rf_wa] = 1'b0;
        if (bus.issue_valid && (bus.issue_wa != XZR))
            pend_d[bus.issue_wa] = 1'b1;
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    assign hit = ((bus.chk_ra1 != XZR) && pend_q[bus.chk_ra1])
              || ((bus.chk_ra2 != XZR) && pend_q[bus.chk_ra2])
              || ((bus.chk_wa  != XZR) && pend_q[bus.chk_wa]);

    assign bus.stall   = hit || (starve_q == SW'(STARVE_MAX));
    assign bus.pending = pend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q  <= 1'b0;
            pend_q   <= '0;
            starve_q <= '0;
        end else begin
            ready_q  <= 1'b1;
            pend_q   <= pend_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        rdy;
        logic        stall;
        logic [31:0] pend;
    } exp_t;

    typedef struct {
        logic [4:0]  wa;
        logic [63:0] wd;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_tgt = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    res_t        mq[$];
    res_t        mcu[$];
    logic [31:0] pend = '0;
    int          cnt = 0;
    bit          init = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", bus.rf_we, e.we);
                chk("rf_wa", bus.rf_wa, e.wa);
                chk("rf_wd", bus.rf_wd, e.wd);
                chk("mc_ready", bus.mc_ready, e.rdy);
                chk("stall", bus.stall, e.stall);
                chk("pending", bus.pending, e.pend);
            end
        end
    end

    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd31) && pend[r];
    endfunction

    task automatic step(
        input bit pwe, input logic [4:0] pwa, input logic [63:0] pwd,
        input bit mv, input logic [4:0] mwa, input logic [63:0] mwd,
        input bit iv, input logic [4:0] iwa,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] cw,
        output bit acc
    );
        bit   ready, pipe, live, hd, byp;
        int   sz;
        exp_t e;
        res_t r;
        @(posedge clk);
        #1;
        rst_n = rst_tgt;
        bus.pipe_we = pwe; bus.pipe_wa = pwa; bus.pipe_wd = pwd;
        bus.mc_valid = mv; bus.mc_wa = mwa; bus.mc_wd = mwd;
        bus.issue_valid = iv; bus.issue_wa = iwa;
        bus.chk_ra1 = r1; bus.chk_ra2 = r2; bus.chk_wa = cw;
        if (!rst_n) begin
            mq.delete();
            pend = '0;
            cnt = 0;
            init = 0;
        end else begin
            assert (!(iv && busy(iwa))) else $error("issue to pending reg");
            assert (!(pwe && busy(pwa))) else $error("pipe to pending reg");
        end
        ready = init && (mq.size() < 2);
        pipe = rst_n && pwe && (pwa != 5'd31);
        acc = mv && ready;
        live = acc && (mwa != 5'd31);
        hd = 0;
        byp = 0;
        e.we = 0; e.wa = 0; e.wd = 0;
        if (pipe) begin
            e.we = 1; e.wa = pwa; e.wd = pwd;
        end else if (mq.size() > 0) begin
            e.we = 1; e.wa = mq[0].wa; e.wd = mq[0].wd; hd = 1;
        end else if (live) begin
            e.we = 1; e.wa = mwa; e.wd = mwd; byp = 1;
        end
        e.rdy = ready;
        e.pend = pend;
        e.stall = busy(r1) || busy(r2) || busy(cw) || (cnt == 4);
        exp_q.push_back(e);
        if (rst_n) begin
            sz = mq.size();
            if (hd) void'(mq.pop_front());
            if (live && !byp) begin
                r.wa = mwa; r.wd = mwd;
                mq.push_back(r);
            end
            if (hd || byp) pend[e.wa] = 1'b0;
            if (iv && iwa != 5'd31) pend[iwa] = 1'b1;
            cnt = (sz == 0 || hd) ? 0 : ((cnt < 4) ? cnt + 1 : 4);
            init = 1;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic do_reset(input int n);
        rst_tgt = 1'b0;
        mcu.delete();
        idle(n);
        rst_tgt = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          acc, mv, iv, pwe, hold;
        logic [4:0]  mwa, iwa, pwa, cand;
        logic [63:0] mwd;
        int          idx, ppct;
        bus.pipe_we = 0; bus.pipe_wa = 0; bus.pipe_wd = 0;
        bus.mc_valid = 0; bus.mc_wa = 0; bus.mc_wd = 0;
        bus.issue_valid = 0; bus.issue_wa = 0;
        bus.chk_ra1 = 0; bus.chk_ra2 = 0; bus.chk_wa = 0;
        idle(3);
        rst_tgt = 1'b1;
        idle(2);
        // Pipe only.
        repeat (3) step(1, 5, 64'hAA, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        // Bypass.
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, acc);
        idle(1);
        step(0, 0, 0, 1, 7, 64'h1234, 0, 0, 7, 0, 0, acc);
        idle(1);
        // Conflict and buffer.
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, acc);
        step(1, 5, 64'h55, 1, 9, 64'h9999, 0, 0, 0, 0, 0, acc);
        idle(2);
        // Full FIFO.
        step(0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, acc);
        idx = 0;
        repeat (6) begin
            step(1, 5, 64'h77, idx < 3, 5'(10 + idx), 64'(100 + idx),
                 0, 0, 10, 11, 12, acc);
            if (acc) idx++;
        end
        repeat (6) begin
            step(0, 0, 0, idx < 3, 5'(10 + idx), 64'(100 + idx),
                 0, 0, 10, 11, 12, acc);
            if (acc) idx++;
        end
        // Starvation.
        step(0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 0, acc);
        repeat (7) step(1, 6, 64'h66, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(1, 6, 64'h66, 1, 13, 64'hD00D, 0, 0, 0, 0, 0, acc);
        repeat (6) step(1, 6, 64'h66, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        idle(3);
        // Scoreboard and reset.
        step(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, acc);
        step(0, 0, 0, 0, 0, 0, 1, 31, 0, 3, 31, acc);
        step(0, 0, 0, 0, 0, 0, 0, 0, 31, 3, 31, acc);
        do_reset(2);
        idle(2);
        // Randomized traffic.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            ppct = ((c / 250) % 2 != 0) ? 85 : 35;
            if (c == 1500) begin
                do_reset(2);
                hold = 0;
            end
            mv = (mcu.size() > 0) && (hold || $urandom_range(0, 2) != 0);
            mwa = mv ? mcu[0].wa : 5'd0;
            mwd = mv ? mcu[0].wd : 64'd0;
            iv = 0;
            iwa = 0;
            if (mcu.size() < 4 && $urandom_range(0, 99) < 35) begin
                cand = 5'($urandom_range(0, 31));
                if (!busy(cand)) begin
                    iv = 1;
                    iwa = cand;
                end
            end
            pwe = $urandom_range(0, 99) < ppct;
            pwa = 5'($urandom_range(0, 31));
            if (busy(pwa) || (iv && pwa == iwa && pwa != 5'd31)) pwe = 0;
            step(pwe, pwa, {$urandom, $urandom}, mv, mwa, mwd, iv, iwa,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), acc);
            if (mv) begin
                if (acc) begin
                    void'(mcu.pop_front());
                    hold = 0;
                end else begin
                    hold = 1;
                end
            end
            if (iv) mcu.push_back('{iwa, {$urandom, $urandom}});
        end
        idle(4);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
